// File: rtl/craft_pkg.sv
// CRAFT primitives shared by the encrypt and decrypt cores: S-box, nibble permutations,
// round constants, MixColumns. Nibble 0 is the most significant nibble of the 64-bit state.
package craft_pkg;

  typedef logic [3:0] nibble_t;
  typedef nibble_t [0:15] nib16_t;
  typedef nib16_t state_t;
  typedef logic [6:0] rc_t;  // {a_i[3:0], b_i[2:0]}

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} dec_state_e;

  localparam nib16_t SBOX_TBL   = 64'hCAD3EBF789150246;
  localparam nib16_t PN_TBL     = 64'hFCDEA98B65471230;
  // PN happens to be its own inverse, so both tables hold the same permutation.
  localparam nib16_t PN_INV_TBL = 64'hFCDEA98B65471230;
  localparam nib16_t Q_TBL      = 64'hCAF5E892B374601D;

  localparam rc_t [0:31] RC_ROM = {
    {4'h1, 3'h1}, {4'h8, 3'h4}, {4'h4, 3'h2}, {4'h2, 3'h5},
    {4'h9, 3'h6}, {4'hC, 3'h7}, {4'h6, 3'h3}, {4'hB, 3'h1},
    {4'h5, 3'h4}, {4'hA, 3'h2}, {4'hD, 3'h5}, {4'hE, 3'h6},
    {4'hF, 3'h7}, {4'h7, 3'h3}, {4'h3, 3'h1}, {4'h1, 3'h4},
    {4'h8, 3'h2}, {4'h4, 3'h5}, {4'h2, 3'h6}, {4'h9, 3'h7},
    {4'hC, 3'h3}, {4'h6, 3'h1}, {4'hB, 3'h4}, {4'h5, 3'h2},
    {4'hA, 3'h5}, {4'hD, 3'h6}, {4'hE, 3'h7}, {4'hF, 3'h3},
    {4'h7, 3'h1}, {4'h3, 3'h4}, {4'h1, 3'h2}, {4'h8, 3'h5}
  };

  function automatic state_t sub_cells(input state_t s);
    state_t r;
    for (int k = 0; k < 16; k++) r[k] = SBOX_TBL[s[k]];
    return r;
  endfunction

  // Gather form: output nibble k takes input nibble tbl[k].
  function automatic state_t permute(input state_t s, input nib16_t tbl);
    state_t r;
    for (int k = 0; k < 16; k++) r[k] = s[tbl[k]];
    return r;
  endfunction

  function automatic state_t add_rc(input state_t s, input rc_t rc);
    state_t r;
    r = s;
    r[4] = s[4] ^ rc[6:3];
    r[5] = s[5] ^ {1'b0, rc[2:0]};
    return r;
  endfunction

  function automatic state_t mix_columns(input state_t s);
    state_t r;
    for (int c = 0; c < 4; c++) begin
      r[c]      = s[c] ^ s[8+c] ^ s[12+c];
      r[4+c]    = s[4+c] ^ s[12+c];
      r[8+c]    = s[8+c];
      r[12+c]   = s[12+c];
    end
    return r;
  endfunction

endpackage

// File: rtl/craft_decrypt_if.sv
// Request/response bundle of the CRAFT decryptor: master issues start with operands,
// slave returns busy/done/plaintext.
interface craft_decrypt_if;
  logic         start;
  logic [63:0]  ciphertext;
  logic [63:0]  tweak;
  logic [127:0] key;
  logic         busy;
  logic         done;
  logic [63:0]  plaintext;

  modport master (output start, ciphertext, tweak, key, input busy, done, plaintext);
  modport slave  (input start, ciphertext, tweak, key, output busy, done, plaintext);
endinterface

// File: rtl/craft_dec_round.sv
// Combinational inverse CRAFT round, zero latency; last_i selects the encryptor's final
// round (no SB/PN), which is the first round undone on decryption.
module craft_dec_round
  import craft_pkg::*;
(
  input  state_t state_i,
  input  state_t tk_i,
  input  rc_t    rc_i,
  input  logic   last_i,
  output state_t state_o
);

  state_t pre;

  always_comb begin
    pre = state_i;
    if (!last_i) pre = permute(sub_cells(state_i), PN_INV_TBL);
    state_o = mix_columns(add_rc(pre ^ tk_i, rc_i));
  end

endmodule

// File: rtl/craft_decrypt.sv
// Iterative CRAFT decryptor: done 32 cycles after an accepted start (16 with CRAFT_DEC_UNROLL2_EN).
// No backpressure: start is ignored while busy; plaintext holds until the next done.
module craft_decrypt
  import craft_pkg::*;
#(
  parameter int NUM_ROUNDS = 32
) (
  input  logic           clk,
  input  logic           rst,
  craft_decrypt_if.slave bus
);

  localparam logic [4:0] FIRST_RND = 5'(NUM_ROUNDS - 1);

  dec_state_e   state_q;
  state_t       s_q;
  state_t       s_d;
  state_t       pt_q;
  state_t [3:0] tk_q;
  logic [4:0]   rnd_q;
  logic         busy_q;
  logic         done_q;
  state_t       tq;

  assign tq = permute(state_t'(bus.tweak), Q_TBL);

`ifdef CRAFT_DEC_UNROLL2_EN
  localparam logic [4:0] STEP = 5'd2;
  logic [4:0] rnd_lo;
  state_t     s_mid;

  assign rnd_lo = rnd_q - 5'd1;

  craft_dec_round u_round_hi (
    .state_i (s_q),
    .tk_i    (tk_q[rnd_q[1:0]]),
    .rc_i    (RC_ROM[rnd_q]),
    .last_i  (rnd_q == FIRST_RND),
    .state_o (s_mid)
  );

  craft_dec_round u_round_lo (
    .state_i (s_mid),
    .tk_i    (tk_q[rnd_lo[1:0]]),
    .rc_i    (RC_ROM[rnd_lo]),
    .last_i  (1'b0),
    .state_o (s_d)
  );
`else
  localparam logic [4:0] STEP = 5'd1;

  craft_dec_round u_round (
    .state_i (s_q),
    .tk_i    (tk_q[rnd_q[1:0]]),
    .rc_i    (RC_ROM[rnd_q]),
    .last_i  (rnd_q == FIRST_RND),
    .state_o (s_d)
  );
`endif

  // Round 0 is terminal: the counter stops there instead of wrapping.
  localparam logic [4:0] LAST_RND = STEP - 5'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      pt_q    <= '0;
      tk_q    <= '0;
      rnd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            s_q     <= state_t'(bus.ciphertext);
            tk_q[0] <= state_t'(bus.key[127:64] ^ bus.tweak);
            tk_q[1] <= state_t'(bus.key[63:0] ^ bus.tweak);
            tk_q[2] <= state_t'(bus.key[127:64]) ^ tq;
            tk_q[3] <= state_t'(bus.key[63:0]) ^ tq;
            rnd_q   <= FIRST_RND;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          s_q <= s_d;
          if (rnd_q == LAST_RND) begin
            pt_q    <= s_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            rnd_q <= rnd_q - STEP;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.plaintext = pt_q;

endmodule

// File: tb/tb_craft_decrypt.sv
// Bench for craft_decrypt: ciphertexts come from a nibble-array CRAFT encryption model;
// the decryptor must return the original plaintext with the documented timing.
module tb_craft_decrypt;

`ifdef CRAFT_DEC_UNROLL2_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 32;
`endif

  logic clk = 1'b0;
  logic rst;

  craft_decrypt_if bus ();

  craft_decrypt #(.NUM_ROUNDS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int SBOX[16] = '{12, 10, 13, 3, 14, 11, 15, 7, 8, 9, 1, 5, 0, 2, 4, 6};
  int PN[16]   = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};
  int QP[16]   = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nib(input logic [63:0] x, input int i);
    return int'((x >> (60 - 4 * i)) & 64'hF);
  endfunction

  // Forward CRAFT; round constants from the two LFSRs rather than a table.
  function automatic logic [63:0] ref_encrypt(input logic [63:0] p, input logic [63:0] t,
                                              input logic [127:0] k);
    int s[16];
    int nx[16];
    int tk[4][16];
    int a;
    int b;
    logic [63:0] r;
    for (int i = 0; i < 16; i++) begin
      tk[0][i] = nib(k[127:64], i) ^ nib(t, i);
      tk[1][i] = nib(k[63:0], i) ^ nib(t, i);
      tk[2][i] = nib(k[127:64], i) ^ nib(t, QP[i]);
      tk[3][i] = nib(k[63:0], i) ^ nib(t, QP[i]);
      s[i] = nib(p, i);
    end
    a = 1;
    b = 1;
    for (int rnd = 0; rnd < 32; rnd++) begin
      for (int c = 0; c < 4; c++) begin
        s[c]   = s[c] ^ s[8+c] ^ s[12+c];
        s[4+c] = s[4+c] ^ s[12+c];
      end
      s[4] = s[4] ^ a;
      s[5] = s[5] ^ b;
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ tk[rnd % 4][i];
      if (rnd != 31) begin
        for (int i = 0; i < 16; i++) nx[PN[i]] = s[i];
        for (int i = 0; i < 16; i++) s[i] = SBOX[nx[i]];
      end
      a = (a >> 1) | (((a ^ (a >> 1)) & 1) << 3);
      b = (b >> 1) | (((b ^ (b >> 1)) & 1) << 2);
    end
    r = '0;
    for (int i = 0; i < 16; i++) r = (r << 4) | 64'(s[i]);
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Called at a negedge with the DUT idle; leaves one cycle after done.
  task automatic run_dec(input string tag, input logic [63:0] p, input logic [63:0] t,
                         input logic [127:0] k, input bit poke);
    int cnt;
    bit seen;
    bus.start      = 1'b1;
    bus.ciphertext = ref_encrypt(p, t, k);
    bus.tweak      = t;
    bus.key        = k;
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < LAT + 8) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) check_eq({tag, "_busy"}, 64'(bus.busy), 64'd1);
      seen = bus.done;
      bus.start      = poke && (cnt == 5 || cnt == 10);
      bus.ciphertext = rand64();
      bus.tweak      = rand64();
      bus.key        = {rand64(), rand64()};
    end
    check_eq({tag, "_lat"}, seen ? 64'(cnt - 1) : 64'hFFFF, 64'(LAT));
    check_eq({tag, "_pt"}, bus.plaintext, p);
    @(negedge clk);
    check_eq({tag, "_pulse"}, 64'(bus.done), 64'd0);
    check_eq({tag, "_hold"}, bus.plaintext, p);
  endtask

  initial begin
    logic [63:0]  pa, ta, pb, tb;
    logic [127:0] ka, kb;
    int cnt;
    int ndone;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.ciphertext = '0;
    bus.tweak = '0;
    bus.key = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_pt", bus.plaintext, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_dec("kat", 64'h5734F006D8D88A3E, 64'h54CD94FFD0670A58,
            128'h27A6781A43F364BC916708D5FBB5AEFE, 1'b0);
    run_dec("zeros", 64'd0, 64'd0, 128'd0, 1'b0);
    run_dec("ones", '1, '1, '1, 1'b0);

    // Extra starts mid-run must be ignored: one done, first request's result.
    run_dec("poke", rand64(), rand64(), {rand64(), rand64()}, 1'b1);
    ndone = 0;
    repeat (LAT + 8) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check_eq("poke_single_done", 64'(ndone), 64'd0);

    // Reset part-way through a run.
    bus.start = 1'b1;
    bus.ciphertext = rand64();
    bus.tweak = rand64();
    bus.key = {rand64(), rand64()};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", 64'(bus.busy), 64'd0);
    check_eq("abort_done", 64'(bus.done), 64'd0);
    check_eq("abort_pt", bus.plaintext, 64'd0);
    rst = 1'b0;
    ndone = 0;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check_eq("abort_no_done", 64'(ndone), 64'd0);
    run_dec("after_abort", rand64(), rand64(), {rand64(), rand64()}, 1'b0);

    // start held through the done cycle chains a second run.
    pa = rand64(); ta = rand64(); ka = {rand64(), rand64()};
    pb = rand64(); tb = rand64(); kb = {rand64(), rand64()};
    bus.start = 1'b1;
    bus.ciphertext = ref_encrypt(pa, ta, ka);
    bus.tweak = ta;
    bus.key = ka;
    @(negedge clk);
    bus.ciphertext = ref_encrypt(pb, tb, kb);
    bus.tweak = tb;
    bus.key = kb;
    cnt = 1;
    while (!bus.done && cnt < LAT + 8) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("b2b_a_lat", 64'(cnt - 1), 64'(LAT));
    check_eq("b2b_a_pt", bus.plaintext, pa);
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 1;
    check_eq("b2b_b_busy", 64'(bus.busy), 64'd1);
    check_eq("b2b_old_pt", bus.plaintext, pa);
    while (!bus.done && cnt < LAT + 8) begin
      @(negedge clk);
      cnt++;
    end
    // Second done arrives LAT+1 cycles after the first (accept edge closes the done cycle).
    check_eq("b2b_gap", 64'(cnt), 64'(LAT + 1));
    check_eq("b2b_b_pt", bus.plaintext, pb);
    @(negedge clk);

    for (int n = 0; n < 1000; n++) begin
      run_dec("loop", rand64(), rand64(), {rand64(), rand64()}, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
